aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
- Shares one aes_cipher_top instance among NREQ independent requesters.
- Round-robin grant; latches the winner's text/key; issues a single-cycle ld to the core; waits for done; returns text_out to the winner with an ID tag.
- Sits between requester ports and the aes_input_buffer/aes_cipher_top path in aes_top; replaces direct ld/text_in/key drive.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must be >= clog2(NREQ)
TIMEOUT, 32, cycles to wait in RUN before abort (used only with AES_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_text  in  NREQ*128  plaintext, requester i at [128*i +: 128]
req_key  in  NREQ*128  key, requester i at [128*i +: 128]
rsp_valid  out  1  result valid
rsp_ready  in  1  result accepted
rsp_id  out  IDW  requester index owning the result
rsp_text  out  128  ciphertext
rsp_err  out  1  result aborted by timeout; tied 0 without AES_ARB_TIMEOUT_EN
core_ld  out  1  load pulse to cipher core
core_text  out  128  latched plaintext to core
core_key  out  128  latched key to core
core_done  in  1  cipher done
core_text_out  in  128  cipher result
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, LOAD, RUN, RESP. Reset (rst=0 at clk edge):
  - state=IDLE; last-grant pointer=NREQ-1, so requester 0 has first priority.
  - core_text, core_key, rsp_text = 0; rsp_id=0; rsp_err=0; timeout counter=0.
  - All outputs low: core_ld, rsp_valid, req_ready, busy.
  - Reset mid-operation abandons the transaction; core is not notified; no rsp is produced.
- IDLE: winner = first i with req_valid[i], scanning pointer+1, pointer+2, ... modulo NREQ.
  - req_ready[winner]=1 combinationally in IDLE only.
  - On valid&ready: latch req_text/req_key slice into core_text/core_key, latch winner into rsp_id and pointer, go LOAD.
  - No valid: stay IDLE, pointer unchanged.
- LOAD: core_ld=1 for exactly one cycle; go RUN. core_done in LOAD is ignored.
- RUN: core_ld=0; wait for core_done=1. On that edge capture core_text_out into rsp_text, rsp_err=0, go RESP. No fixed latency is assumed (nominal core is ~12 cycles).
- RESP: rsp_valid=1; rsp_text/rsp_id/rsp_err stable.
  - On rsp_ready=1: go IDLE, rsp_valid drops next cycle.
  - rsp_ready held low: stay in RESP indefinitely; no new grant.
- Latency: accept-to-core_ld = 1 cycle; core_done-to-rsp_valid = 1 cycle; rsp accept-to-next req_ready = 1 cycle.
- core_text/core_key hold their value after LOAD until the next accept (input buffer may sample late).
- req_valid deassertion after acceptance has no effect. A requester dropping valid in IDLE before acceptance loses nothing.
- Stray core_done in IDLE or RESP is ignored.

Optional Feature:
- Macro AES_ARB_TIMEOUT_EN.
- Defined: counter clears on entry to RUN and increments each RUN cycle. If it reaches TIMEOUT with no core_done, go RESP with rsp_text=0, rsp_err=1, same rsp_id. core_done arriving on the same edge as the timeout wins (normal result, rsp_err=0).
- Undefined: no counter; RUN waits forever; rsp_err constant 0.

Test Plan:
- Single request: req 2, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, real core -> one core_ld pulse; rsp_valid with rsp_id=2, rsp_text=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
- Fairness: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; each rsp_id matches; no requester granted twice in 4.
- Backpressure: rsp_ready low for 10 cycles after rsp_valid, req_valid[1] high -> rsp_valid/rsp_text stable for 10 cycles, req_ready all 0, core_ld not asserted until after accept.
- Reset mid-RUN: rst=0 for 1 cycle 5 cycles after core_ld -> next cycle busy=0, rsp_valid=0; later core_done produces no rsp; next request with req 0 and req 3 valid grants 0.
- Timeout (AES_ARB_TIMEOUT_EN, TIMEOUT=32, core stub never asserts done) -> rsp_valid 33 cycles after entering RUN, rsp_err=1, rsp_text=0. Without macro -> busy stays 1 for 1000 cycles.
- Stray done: core_done pulsed in IDLE and in LOAD -> no rsp_valid; transaction completes only on the RUN done.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin sharing of one AES core among NREQ requesters; define AES_ARB_TIMEOUT_EN to abort a RUN that outlasts TIMEOUT cycles
module aes_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_text,
  input  logic [NREQ*128-1:0] req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [127:0]        rsp_text,
  output logic                rsp_err,
  output logic                core_ld,
  output logic [127:0]        core_text,
  output logic [127:0]        core_key,
  input  logic                core_done,
  input  logic [127:0]        core_text_out,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, win;
  logic found, accept, tmo, finish;
  if (NREQ < 2 || NREQ > 8 || IDW < $clog2(NREQ) || TIMEOUT < 1) begin : g_cfg_check
    $error("aes_req_arbiter: illegal parameter set");
  end
  // winner is the valid requester with the smallest distance past the last grant
  always_comb begin
    int best, d;
    best = NREQ;
    d = 0;
    win = '0;
    for (int k = 0; k < NREQ; k++) begin
      d = (k + 2 * NREQ - 1 - int'(ptr)) % NREQ;
      if (req_valid[k] && d < best) begin
        best = d;
        win = IDW'(k);
      end
    end
    found = best < NREQ;
  end
  assign accept    = rst && state == IDLE && found;
  assign req_ready = accept ? NREQ'(1) << win : '0;
  assign core_ld   = state == LOAD;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  assign finish    = state == RUN && (core_done || tmo);
  // next-state: one load cycle, wait for done (or timeout), hold result until taken
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? LOAD : IDLE;
      LOAD:    state_nx = RUN;
      RUN:     state_nx = finish ? RESP : RUN;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // latch winner's operands on accept and the core result on completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= IDW'(NREQ - 1);
      rsp_id    <= '0;
      core_text <= '0;
      core_key  <= '0;
      rsp_text  <= '0;
    end else begin
      if (accept) begin
        ptr       <= win;
        rsp_id    <= win;
        core_text <= req_text[128*win +: 128];
        core_key  <= req_key[128*win +: 128];
      end
      if (finish) rsp_text <= core_done ? core_text_out : '0;
    end
  end
`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = cnt == CW'(TIMEOUT);
  // count RUN cycles; a done on the timeout edge still wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      if (finish) rsp_err <= !core_done;
    end
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: scoreboard bench for aes_req_arbiter driving a behavioural cipher-core stub
module tb_aes_req_arbiter;
  localparam int NREQ = 4, IDW = 2, TIMEOUT = 32;
  logic clk = 1'b0, rst = 1'b0, rsp_ready = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*128-1:0] req_text, req_key;
  logic rsp_valid, rsp_err, core_ld, core_done, busy;
  logic [IDW-1:0] rsp_id;
  logic [127:0] rsp_text, core_text, core_key;
  logic [127:0] core_text_out = '0;
  logic stub_done = 1'b0, stray_done = 1'b0, stub_en = 1'b1;
  int stub_lat = 12;
  logic [127:0] txt [NREQ];
  logic [127:0] key [NREQ];
  int issued [NREQ];
  int granted [NREQ];
  int checks = 0, errors = 0, ld_cnt = 0;
  typedef struct {
    logic [IDW-1:0] id;
    logic [127:0]   txt;
    logic           err;
  } rsp_t;
  rsp_t sb [$];

  aes_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_text(req_text), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_text(rsp_text), .rsp_err(rsp_err),
    .core_ld(core_ld), .core_text(core_text), .core_key(core_key),
    .core_done(core_done), .core_text_out(core_text_out), .busy(busy)
  );

  always #5 clk = ~clk;
  assign core_done = stub_done | stray_done;
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req_valid[i] = issued[i] != granted[i];
    assign req_text[128*i +: 128] = txt[i];
    assign req_key[128*i +: 128] = key[i];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input int i);
    return txt[i] ^ {key[i][63:0], key[i][127:64]};
  endfunction

  task automatic push_exp(input int i, input logic err);
    rsp_t e;
    e.id  = IDW'(i);
    e.txt = err ? 128'h0 : model(i);
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic issue(input int i);
    issued[i]++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 128'(sb.size()), 128'h0);
      sb.delete();
    end
    step();
  endtask

  task automatic wait_ld(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_ld && n < max);
    chk("ld_wait", 128'(core_ld), 128'(1));
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < max);
    chk("rsp_wait", 128'(rsp_valid), 128'(1));
  endtask

  // core stub: done pulses stub_lat cycles after a load is seen
  initial begin
    int s_cnt;
    logic ld_seen;
    s_cnt = 0;
    forever begin
      @(negedge clk);
      ld_seen = core_ld;
      @(posedge clk);
      #1;
      stub_done = 1'b0;
      if (ld_seen) s_cnt = stub_en ? stub_lat : 0;
      else if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) begin
          stub_done = 1'b1;
          core_text_out = core_text ^ {core_key[63:0], core_key[127:64]};
        end
      end
    end
  end

  // monitor: grant bookkeeping, load count and scoreboard compare on response handshake
  initial begin
    rsp_t e;
    logic [NREQ-1:0] g;
    forever begin
      @(negedge clk);
      g = rst ? (req_valid & req_ready) : '0;
      if (core_ld) ld_cnt++;
      if (rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("rsp_unexpected", 128'(1), 128'(0));
        else begin
          e = sb.pop_front();
          chk("rsp_id", 128'(rsp_id), 128'(e.id));
          chk("rsp_text", rsp_text, e.txt);
          chk("rsp_err", 128'(rsp_err), 128'(e.err));
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) if (g[k]) granted[k]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, seen;
    for (int k = 0; k < NREQ; k++) begin
      txt[k] = {$urandom, $urandom, $urandom, $urandom};
      key[k] = {$urandom, $urandom, $urandom, $urandom};
    end
    txt[2] = 128'h00112233445566778899aabbccddeeff;
    key[2] = 128'h000102030405060708090a0b0c0d0e0f;
    rsp_ready = 1'b1;
    issue(2);
    push_exp(2, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_core_ld", 128'(core_ld), 128'(0));
    chk("rst_core_text", core_text, 128'h0);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_rsp_text", rsp_text, 128'h0);
    chk("rst_rsp_id", 128'(rsp_id), 128'(0));
    chk("rst_rsp_err", 128'(rsp_err), 128'(0));
    step();
    rst = 1'b1;
    // single request from requester 2
    @(negedge clk);
    chk("t1_req_ready", 128'(req_ready), 128'(4'b0100));
    @(negedge clk);
    chk("t1_ld", 128'(core_ld), 128'(1));
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_core_text", core_text, txt[2]);
    chk("t1_core_key", core_key, key[2]);
    @(negedge clk);
    chk("t1_ld_pulse", 128'(core_ld), 128'(0));
    drain(100);
    chk("t1_ld_cnt", 128'(ld_cnt), 128'(1));
    @(negedge clk);
    chk("t1_idle", 128'(busy), 128'(0));
    // fairness from reset: 0,1,2,3,0,1
    step();
    reset_pulse();
    base = ld_cnt;
    push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0);
    push_exp(3, 1'b0); push_exp(0, 1'b0); push_exp(1, 1'b0);
    issue(0); issue(0); issue(1); issue(1); issue(2); issue(3);
    drain(400);
    chk("t2_ld_cnt", 128'(ld_cnt - base), 128'(6));
    chk("t2_pending", 128'(req_valid), 128'(0));
    // backpressure with a second request from 1 waiting
    rsp_ready = 1'b0;
    push_exp(1, 1'b0); push_exp(1, 1'b0);
    issue(1); issue(1);
    wait_rsp(100, n);
    for (int c = 0; c < 10; c++) begin
      chk("t3_valid", 128'(rsp_valid), 128'(1));
      chk("t3_text", rsp_text, model(1));
      chk("t3_id", 128'(rsp_id), 128'(1));
      chk("t3_req_ready", 128'(req_ready), 128'(0));
      chk("t3_ld", 128'(core_ld), 128'(0));
      @(negedge clk);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_next_ready", 128'(req_ready), 128'(4'b0010));
    chk("t3_next_ld_early", 128'(core_ld), 128'(0));
    @(negedge clk);
    chk("t3_next_ld", 128'(core_ld), 128'(1));
    drain(100);
    // reset in the middle of RUN abandons the transaction
    issue(0);
    wait_ld(50);
    repeat (5) step();
    reset_pulse();
    @(negedge clk);
    chk("t4_busy", 128'(busy), 128'(0));
    chk("t4_rsp_valid", 128'(rsp_valid), 128'(0));
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("t4_no_rsp", 128'(seen), 128'(0));
    step();
    push_exp(0, 1'b0); push_exp(3, 1'b0);
    issue(0); issue(3);
    @(negedge clk);
    chk("t4_first_grant", 128'(req_ready), 128'(4'b0001));
    drain(100);
    // stray done in IDLE and in LOAD
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    @(negedge clk);
    chk("t5_idle_stray", 128'({rsp_valid, busy}), 128'(0));
    step();
    base = ld_cnt;
    push_exp(2, 1'b0);
    issue(2);
    @(negedge clk);
    chk("t5_req_ready", 128'(req_ready), 128'(4'b0100));
    step();
    stray_done = 1'b1;
    @(negedge clk);
    chk("t5_ld", 128'(core_ld), 128'(1));
    step();
    stray_done = 1'b0;
    wait_rsp(100, n);
    chk("t5_latency", 128'(n), 128'(stub_lat + 2));
    drain(50);
    chk("t5_ld_cnt", 128'(ld_cnt - base), 128'(1));
    // core never finishes
    stub_en = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
    push_exp(3, 1'b1);
    issue(3);
    wait_ld(50);
    wait_rsp(200, n);
    chk("t6_tmo_latency", 128'(n), 128'(TIMEOUT + 2));
    chk("t6_tmo_err", 128'(rsp_err), 128'(1));
    drain(50);
`else
    issue(3);
    wait_ld(50);
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy && !rsp_valid) seen++;
    end
    chk("t6_hang", 128'(seen), 128'(1000));
    step();
    reset_pulse();
`endif
    stub_en = 1'b1;
    @(negedge clk);
    chk("end_idle", 128'(busy), 128'(0));
    chk("end_sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
